// File: rtl/adc_moving_average.sv
// adc_moving_average: sliding-window mean of the last 2^LOG2_DEPTH ADC samples.
module adc_moving_average #(
   parameter int DATA_W     = 8,
   parameter int LOG2_DEPTH = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              clear,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   output logic              primed
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int ACC_W = DATA_W + LOG2_DEPTH;
   typedef enum logic {FILL, RUN} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] ring [DEPTH];
   logic [ACC_W-1:0] acc, acc_nxt, oldest;
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH:0] fill_cnt;
   logic accept, completing;
   assign accept     = sample_valid & ~clear;
   assign completing = (state == FILL) && (fill_cnt == (LOG2_DEPTH+1)'(DEPTH-1));
   assign primed     = (state == RUN);
   // In FILL the slot under wr_ptr has never been written, so nothing leaves the sum
   assign oldest     = (state == RUN) ? {{LOG2_DEPTH{1'b0}}, ring[wr_ptr]} : '0;
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc + {{LOG2_DEPTH{1'b0}}, sample_in} - oldest;
      if (clear) state_nxt = FILL;
      else if (accept && completing) state_nxt = RUN;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FILL;
         acc       <= '0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         avg_out   <= '0;
         avg_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         avg_valid <= accept;
         if (clear) begin
            acc      <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
         end else if (accept) begin
            acc     <= acc_nxt;
            wr_ptr  <= wr_ptr + 1'b1;
            avg_out <= (state == FILL && !completing) ? sample_in : acc_nxt[ACC_W-1:LOG2_DEPTH];
            if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (accept) ring[wr_ptr] <= sample_in;
   end
endmodule

// File: tb/tb_adc_moving_average.sv
// tb_adc_moving_average: directed scoreboard bench for the moving-average filter.
module tb_adc_moving_average;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       clear;
   logic [7:0] avg_out;
   logic       avg_valid;
   logic       primed;
   int vectors = 0;
   int miscompares = 0;
   typedef struct {
      logic [7:0] avg;
      logic       pr;
      logic       vld;
   } exp_t;
   exp_t sbq[$];
   int win[$];
   logic [7:0] last_avg = 8'h00;
   adc_moving_average #(.DATA_W(8), .LOG2_DEPTH(3)) dut (
      .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .clear(clear), .avg_out(avg_out), .avg_valid(avg_valid), .primed(primed)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Reference window kept as a plain queue; mean recomputed from scratch each time.
   task automatic model(input logic [7:0] v, input logic sv, input logic clr);
      exp_t e;
      int sum;
      if (clr) win.delete();
      else if (sv) begin
         if (win.size() == 8) void'(win.pop_front());
         win.push_back(int'(v));
         sum = 0;
         foreach (win[i]) sum += win[i];
         last_avg = (win.size() == 8) ? 8'(sum / 8) : v;
      end
      e.avg = last_avg;
      e.pr  = (win.size() == 8);
      e.vld = sv && !clr;
      sbq.push_back(e);
   endtask
   task automatic step(input logic [7:0] v, input logic sv, input logic clr);
      exp_t e;
      sample_in = v;
      sample_valid = sv;
      clear = clr;
      model(v, sv, clr);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      clear = 1'b0;
      e = sbq.pop_front();
      chk("avg_valid", 32'(avg_valid), 32'(e.vld));
      chk("avg_out", 32'(avg_out), 32'(e.avg));
      chk("primed", 32'(primed), 32'(e.pr));
   endtask
   initial begin
      logic [7:0] step_exp [8];
      step_exp = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};
      reset_n = 1'b0;
      sample_in = 8'h00;
      sample_valid = 1'b0;
      clear = 1'b0;
      #12;
      chk("reset_avg_out", 32'(avg_out), 32'h0);
      chk("reset_avg_valid", 32'(avg_valid), 32'h0);
      chk("reset_primed", 32'(primed), 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         step(8'h10, 1'b1, 1'b0);
         chk("fill_const", 32'(avg_out), 32'h10);
         chk("fill_primed", 32'(primed), (i == 7) ? 32'h1 : 32'h0);
         step(8'h00, 1'b0, 1'b0);
      end
      for (int i = 0; i < 8; i++) step(8'h00, 1'b1, 1'b0);
      chk("zero_window", 32'(avg_out), 32'h0);
      for (int i = 0; i < 8; i++) begin
         step(8'hFF, 1'b1, 1'b0);
         chk("step_resp", 32'(avg_out), 32'(step_exp[i]));
      end
      for (int i = 0; i < 7; i++) step(8'd3, 1'b1, 1'b0);
      step(8'd4, 1'b1, 1'b0);
      chk("trunc_25", 32'(avg_out), 32'd3);
      step(8'd10, 1'b1, 1'b0);
      chk("trunc_32", 32'(avg_out), 32'd4);
      step(8'd0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(8'(i), 1'b1, 1'b0);
      chk("ramp_last", 32'(avg_out), 32'd15);
      step(8'd0, 1'b0, 1'b0);
      chk("hold_idle", 32'(avg_out), 32'd15);
      step(8'h55, 1'b1, 1'b1);
      chk("clear_hold", 32'(avg_out), 32'd15);
      chk("clear_primed", 32'(primed), 32'h0);
      step(8'h42, 1'b1, 1'b0);
      chk("after_clear", 32'(avg_out), 32'h42);
      for (int i = 0; i < 9; i++) step(8'(8'h30 + i), 1'b1, 1'b0);
      chk("run_before_rst", 32'(primed), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_avg_out", 32'(avg_out), 32'h0);
      chk("async_avg_valid", 32'(avg_valid), 32'h0);
      chk("async_primed", 32'(primed), 32'h0);
      win.delete();
      last_avg = 8'h00;
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         step(8'h10, 1'b1, 1'b0);
         chk("recover_primed", 32'(primed), (i == 7) ? 32'h1 : 32'h0);
      end
      chk("recover_avg", 32'(avg_out), 32'h10);
      step(8'h00, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/adc_moving_average.md
Name: adc_moving_average

Overview:
- Sliding-window moving-average filter between the ADC0808 controller and the binary-to-BCD/seven-segment path.
- Accepts one 8-bit conversion result per strobe from the ADC control stage.
- Keeps the last 2^LOG2_DEPTH samples in a ring buffer and outputs their mean as an 8-bit value that downstream can convert and display.
- Suppresses display flicker caused by LSB noise on the analog input.

Parameters:
- DATA_W, 8, sample and average width in bits.
- LOG2_DEPTH, 3, log2 of window length (window = 8 samples). Legal range 1..6.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sample_in  input  DATA_W  conversion result from the ADC controller. Valid only while sample_valid=1.
- sample_valid  input  1  single-cycle strobe: sample_in holds a new result
- clear  input  1  synchronous flush of window and accumulator
- avg_out  output  DATA_W  filtered value, held between updates
- avg_valid  output  1  single-cycle pulse, one cycle after each accepted sample
- primed  output  1  high once the window holds 2^LOG2_DEPTH samples since the last reset/clear

Behaviour:
- Reset is asynchronous, active-low, on clk and reset_n. Clock and reset are as already decided.
- Reset values:
  - avg_out=0, avg_valid=0, primed=0
  - accumulator=0, wr_ptr=0, fill_cnt=0
- Ring-buffer contents are not reset. They are never read before being written (see fill rule).
- Accumulator width is DATA_W+LOG2_DEPTH bits, unsigned. It never overflows: at most 2^LOG2_DEPTH samples of at most 2^DATA_W-1 each.
- States:
  - FILL (fill_cnt < DEPTH, primed=0)
  - RUN (primed=1)
- Accepted sample (sample_valid=1, clear=0), in FILL:
  - buf[wr_ptr] <= sample_in
  - acc <= acc + sample_in
  - fill_cnt increments
  - on reaching DEPTH, primed goes 1 at the same edge as the update that completes the window
- Accepted sample in RUN:
  - oldest = buf[wr_ptr], read before overwrite
  - acc <= acc + sample_in - oldest
  - buf[wr_ptr] <= sample_in
- wr_ptr increments modulo DEPTH on every accepted sample and wraps DEPTH-1 -> 0.
- Output update, registered one cycle after acceptance, with avg_valid=1 for exactly that cycle:
  - In FILL, excluding the completing sample: avg_out = sample_in (raw pass-through, so the display shows a value immediately after reset).
  - On the completing sample and throughout RUN: avg_out = new acc >> LOG2_DEPTH (truncating floor, no rounding).
- Latency: sample_valid edge N -> avg_out and avg_valid change at edge N+1.
- sample_valid=0: no state change, avg_out held, avg_valid=0.
- Back-to-back strobes on consecutive cycles are legal. Each is processed; the accumulator read-modify-write completes in one cycle.
- clear=1: next edge sets acc=0, wr_ptr=0, fill_cnt=0, primed=0, avg_valid=0. avg_out is held at its last value.
- clear and sample_valid in the same cycle: clear wins and the sample is discarded.
- reset_n asserted mid-operation: all registers listed above return to reset values immediately, independent of clk. The first strobe after release is treated as sample 1 of FILL.
- No backpressure. The block always accepts a strobe.

Test Plan:
- Reset then 8 strobes of 0x10:
  - samples 1..7 give avg_out=0x10, primed=0
  - 8th gives avg_out=0x10, primed=1
  - avg_valid pulses exactly 8 times, each one cycle after its strobe
- Step response, primed window of 0x00, then strobes of 0xFF:
  - avg_out sequence 0x1F, 0x3F, 0x5F, 0x7F, 0x9F, 0xBF, 0xDF, 0xFF
  - accumulator peaks at 0x7F8 with no overflow
- Truncation, window filled with 3,3,3,3,3,3,3,4 (sum 25):
  - avg_out=3
  - next sample 10 replaces oldest 3: sum 32, avg_out=4
- Back-to-back strobes every cycle for 20 samples of an incrementing ramp 0..19:
  - after the last sample, avg_out = floor((12+...+19)/8) = 15
  - wr_ptr wrap is exercised twice
- clear asserted with sample_valid high in the same cycle:
  - sample ignored, primed=0, avg_out holds prior value
  - the next strobe of 0x42 gives avg_out=0x42 (FILL pass-through)
- Async reset asserted between clock edges mid-RUN:
  - avg_out, avg_valid, primed read 0 before the next edge
  - recovery follows scenario 1
